mmio_timer_bank: RTL

//  Memory-mapped bank of N_CH independent up-counting timers on the peripheral bus (wen/addr/wdata/rdata).

---
 rtl/mmio_timer_bank_pkg.sv | 34 +++
 rtl/mmio_timer_bank_ch.sv | 149 ++++++++++++++
 rtl/mmio_timer_bank.sv | 70 +++++++
 3 files changed

// File: rtl/mmio_timer_bank_pkg.sv
// Shared constants, bus write payload and decode helper for the mmio_timer_bank timer bank.
// The optional per-channel interrupt is built when TIMER_BANK_IRQ_EN is defined.
package mmio_timer_bank_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned OFF_W    = 5;
  localparam int unsigned CH_IDX_W = 3;

  localparam logic [BUS_W-1:0] PERI_ADDR_TMRBANK = 32'hFFFF_F100;

  // Register offsets inside one 32-byte channel window
  localparam logic [OFF_W-1:0] TMR_OFF_CTRL  = 5'h00;
  localparam logic [OFF_W-1:0] TMR_OFF_PRESC = 5'h04;
  localparam logic [OFF_W-1:0] TMR_OFF_CNT   = 5'h08;
  localparam logic [OFF_W-1:0] TMR_OFF_CMP   = 5'h0C;
  localparam logic [OFF_W-1:0] TMR_OFF_STAT  = 5'h10;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_ONESHOT_BIT = 1;
  localparam int unsigned CTRL_IE_BIT      = 2;
  localparam int unsigned STAT_MATCH_BIT   = 0;

  typedef struct packed {
    logic             wen;
    logic [OFF_W-1:0] off;
    logic [BUS_W-1:0] wdata;
  } tmr_wr_t;

  // Bank hit on the upper 24 address bits (bank is 256-byte aligned)
  function automatic logic bank_hit(input logic [23:0] addr_hi, input logic [23:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/mmio_timer_bank_ch.sv
// One timer channel: CTRL/PRESC/CNT/CMP/STAT registers, prescaler, up-counter and sticky match.
// With TIMER_BANK_IRQ_EN defined, CTRL.IE is stored and a registered irq = MATCH & IE is produced.
module mmio_timer_bank_ch
  import mmio_timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  tmr_wr_t          wr_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic [BUS_W-1:0] rd_data_c,
  output logic             irq_o
);

  logic             en_q, en_d;
  logic             oneshot_q, oneshot_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;

  logic tick_c;
  logic at_top_c;
  logic match_set_c;
  logic unused_wdata_c;

  // Bits above CNT_W (and IE when not built) are intentionally ignored
  assign unused_wdata_c = ^wr_i.wdata;

  assign tick_c      = en_q && (pcnt_q == presc_q);
  assign at_top_c    = (cnt_q == cmp_q);
  assign match_set_c = tick_c && at_top_c;

`ifdef TIMER_BANK_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;
`endif

  // Next state: tick update first, then bus write overrides, then match set wins over W1C
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    match_d   = match_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
`ifdef TIMER_BANK_IRQ_EN
    ie_d      = ie_q;
    irq_d     = match_q & ie_q;
`endif

    if (en_q) begin
      pcnt_d = tick_c ? '0 : pcnt_q + CNT_W'(1);
    end
    if (tick_c) begin
      cnt_d = at_top_c ? '0 : cnt_q + CNT_W'(1);
    end
    if (match_set_c && oneshot_q) begin
      en_d = 1'b0;
    end

    if (wr_i.wen) begin
      case (wr_i.off)
        TMR_OFF_CTRL: begin
          en_d      = wr_i.wdata[CTRL_EN_BIT];
          oneshot_d = wr_i.wdata[CTRL_ONESHOT_BIT];
`ifdef TIMER_BANK_IRQ_EN
          ie_d      = wr_i.wdata[CTRL_IE_BIT];
`endif
        end
        TMR_OFF_PRESC: begin
          presc_d = wr_i.wdata[CNT_W-1:0];
          pcnt_d  = '0;
        end
        TMR_OFF_CNT:  cnt_d = wr_i.wdata[CNT_W-1:0];
        TMR_OFF_CMP:  cmp_d = wr_i.wdata[CNT_W-1:0];
        TMR_OFF_STAT: begin
          if (wr_i.wdata[STAT_MATCH_BIT]) begin
            match_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (match_set_c) begin
      match_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      cmp_q     <= '0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
    end
  end

`ifdef TIMER_BANK_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Combinational register view; the top registers the selected word
  always_comb begin
    rd_data_c = '0;
    case (rd_off_i)
      TMR_OFF_CTRL: begin
        rd_data_c[CTRL_EN_BIT]      = en_q;
        rd_data_c[CTRL_ONESHOT_BIT] = oneshot_q;
`ifdef TIMER_BANK_IRQ_EN
        rd_data_c[CTRL_IE_BIT]      = ie_q;
`endif
      end
      TMR_OFF_PRESC: rd_data_c = 32'(presc_q);
      TMR_OFF_CNT:   rd_data_c = 32'(cnt_q);
      TMR_OFF_CMP:   rd_data_c = 32'(cmp_q);
      TMR_OFF_STAT:  rd_data_c[STAT_MATCH_BIT] = match_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of N_CH independent timers: address decode, per-channel writes, registered read mux.
// Define TIMER_BANK_IRQ_EN to build the per-channel CTRL.IE bit and irq outputs.
module mmio_timer_bank
  import mmio_timer_bank_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = PERI_ADDR_TMRBANK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq
);

  logic [CH_IDX_W-1:0] ch_c;
  logic [OFF_W-1:0]    off_c;
  logic                hit_c;
  logic [BUS_W-1:0]    ch_rd_c [N_CH];
  logic [BUS_W-1:0]    rdata_q, rdata_d;

  // Channel slots beyond N_CH are holes in the map
  assign ch_c  = addr[7:5];
  assign off_c = addr[4:0];
  assign hit_c = bank_hit(addr[31:8], BASE_ADDR[31:8]) && (32'(ch_c) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tmr_wr_t wr_c;

    always_comb begin
      wr_c.wen   = wen && hit_c && (ch_c == CH_IDX_W'(i));
      wr_c.off   = off_c;
      wr_c.wdata = wdata;
    end

    mmio_timer_bank_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr_c),
      .rd_off_i  (off_c),
      .rd_data_c (ch_rd_c[i]),
      .irq_o     (irq[i])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (hit_c && (ch_c == CH_IDX_W'(i))) begin
        rdata_d = ch_rd_c[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
